// File: rtl/shared_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_ctrl
// Description : Shared data-memory controller behind the core arbiter.
//               Takes one granted single-word request at a time, accesses the
//               shared RAM and returns read data with a one-cycle completion
//               pulse. It also flags grant-protocol violations and keeps a
//               saturating completed-access counter for each core.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_ctrl #(
  parameter int NUM_CORES = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,        // asynchronous, active low
  input  logic [NUM_CORES-1:0]              gnt_arb,
  input  logic [NUM_CORES-1:0]              mem_req,
  input  logic [NUM_CORES-1:0]              mem_we,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0]  mem_addr,
  input  logic [NUM_CORES-1:0][DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]                 mem_rdata,
  output logic [NUM_CORES-1:0]              mem_done,
  output logic                              mem_err,
  output logic [NUM_CORES-1:0][CNT_W-1:0]   acc_cnt
);

  localparam int OWN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [OWN_W-1:0]                  owner_q, owner_d;
  logic [ADDR_W-1:0]                 addr_q,  addr_d;
  logic                              we_q,    we_d;
  logic [DATA_W-1:0]                 wdata_q, wdata_d;
  logic [DATA_W-1:0]                 rdata_q, rdata_d;
  logic [NUM_CORES-1:0]              done_q,  done_d;
  logic                              err_q,   err_d;
  logic [NUM_CORES-1:0][CNT_W-1:0]   cnt_q,   cnt_d;

  logic [NUM_CORES-1:0]              hit;
  logic [OWN_W-1:0]                  hit_idx;
  logic [DATA_W-1:0]                 ram_rd;

  // Shared storage; deliberately not reset.
  logic [DATA_W-1:0] ram [2**ADDR_W];

  assign ram_rd = ram[addr_q];

  // Request decode, FSM next state, and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    hit     = mem_req & gnt_arb;
    hit_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit[i]) hit_idx = OWN_W'(i);
    end

    case (state_q)
      IDLE: begin
        // A multi-bit grant with any live request is a violation even if
        // only one of the granted cores is actually requesting.
        if (!$onehot0(gnt_arb) && (|mem_req)) begin
          err_d = 1'b1;
        end else if ($onehot(hit)) begin
          owner_d = hit_idx;
          addr_d  = mem_addr[hit_idx];
          we_d    = mem_we[hit_idx];
          wdata_d = mem_wdata[hit_idx];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = ram_rd;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (owner_q == OWN_W'(i)) done_d[i] = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if ((owner_q == OWN_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; asynchronous reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM write at the closing edge of ACCESS; reset forces IDLE so an
  // access interrupted before that edge never commits.
  always_ff @(posedge clk) begin
    if ((state_q == ACCESS) && we_q) ram[addr_q] <= wdata_q;
  end

  assign mem_rdata = rdata_q;
  assign mem_done  = done_q;
  assign mem_err   = err_q;
  assign acc_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: doc/shared_mem_ctrl.md
Name: shared_mem_ctrl

Overview:
- Shared data-memory controller directly downstream of the multicore CPU cluster and its arbiter.
- Consumes each core's memory request (12-bit address, 8-bit data, read/write) qualified by the arbiter's grant vector.
- Performs the single-word access to an on-chip NUM_CORES-shared RAM and returns read data with a per-core completion pulse.
- Also flags grant-protocol violations and keeps per-core access counters.

Parameters:
NUM_CORES, 3, number of requesting cores / width of grant and request vectors
ADDR_W, 12, address width; RAM depth = 2**ADDR_W words
DATA_W, 8, data word width
CNT_W, 16, width of each per-core access counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
gnt_arb  input  NUM_CORES  one-hot grant from arbiter, bit i = core i owns memory
mem_req  input  NUM_CORES  per-core access request, level, held until mem_done
mem_we  input  NUM_CORES  per-core write enable (1 = write, 0 = read)
mem_addr  input  NUM_CORES x ADDR_W  per-core address
mem_wdata  input  NUM_CORES x DATA_W  per-core write data
mem_rdata  output  DATA_W  read data of the completing access
mem_done  output  NUM_CORES  one-cycle completion pulse to the owning core
mem_err  output  1  one-cycle pulse: grant-protocol violation
acc_cnt  output  NUM_CORES x CNT_W  completed-access count per core

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; mem_rdata = 0; mem_done = 0; mem_err = 0; all acc_cnt = 0; latched owner/addr/we/wdata cleared. RAM contents are not reset.
- Reset mid-access: any pending access is abandoned and no done pulse is issued. A write is committed only if the ACCESS edge occurred before rst fell.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Each cycle, evaluate hit = mem_req & gnt_arb.
  - Exactly one hit bit set: latch owner index, that core's addr/we/wdata; go to ACCESS.
  - More than one gnt_arb bit set while any mem_req is high: mem_err = 1 for the next cycle; no access; stay IDLE.
  - hit = 0 (request without grant, or grant without request): stay IDLE, no effect.
- ACCESS (1 cycle):
  - Write: RAM[addr] <= wdata at the closing edge; mem_rdata unchanged.
  - Read: mem_rdata <= RAM[addr] at the closing edge.
  - Go to DONE.
- DONE (1 cycle):
  - mem_done[owner] = 1, all other bits 0; mem_rdata valid for reads.
  - acc_cnt[owner] increments at the closing edge, saturating at 2**CNT_W-1.
  - Go to IDLE.
- Latency: request/grant sampled at edge N; done visible in cycle N+2; rdata stable from N+2 until the next read completes.
- Requester rule: the core drops mem_req in the cycle following its mem_done pulse. A req still high at the end of that cycle (with grant) starts a new access; this is legal back-to-back use, giving 3-cycle throughput.
- Grant changes while in ACCESS/DONE are ignored; the latched owner completes.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Address wraps naturally within ADDR_W bits; no out-of-range case exists.

Test Plan:
- Reset: hold rst low 3 cycles mid-run -> mem_done=0, mem_err=0, mem_rdata=0x00, all acc_cnt=0 immediately (asynchronous).
- Write/read: core0 granted, write 0xA5 to 0x123, then read 0x123 -> mem_done[0] pulses 2 cycles after each sample; read returns mem_rdata=0xA5; acc_cnt[0]=2.
- Multi-core sharing: core1 writes 0x3C to 0xFFF, core2 reads 0xFFF under successive one-hot grants -> core2 mem_rdata=0x3C; only mem_done[2] pulses on the read; acc_cnt[1]=1, acc_cnt[2]=1.
- Protocol: mem_req=3'b011 with gnt_arb=3'b011 -> mem_err pulses 1 cycle, no mem_done, RAM unchanged. Then req without grant (req=3'b100, gnt=0) -> no activity.
- Back-to-back: core0 holds mem_req through 4 accesses under continuous grant -> mem_done[0] pulses every 3 cycles; acc_cnt[0]=4.
- Reset mid-access: assert rst while in ACCESS of a write of 0x77 to 0x010 (before the ACCESS edge), then read 0x010 -> old value returned, no done pulse for the aborted write.
